// File: rtl/viterbi_decoder2.sv
// Hard-decision Viterbi decoder for the rate-1/2, 8-state code.
// Register-exchange survivors, subtract-minimum metrics, and a flush of pending bits at end of frame.
module viterbi_decoder2 #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic [1:0] d_in,
  output logic       ready_o,
  output logic       valid_o,
  output logic       d_out
);

  localparam int unsigned    CW      = $clog2(TB_DEPTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TB_DEPTH - 1);
  localparam logic [PM_W-1:0] PM_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                r_state;
  logic                  r_valid;
  logic                  r_dout;
  logic                  r_ready;
  logic [CW-1:0]         r_count;
  logic [2:0]            r_best;
  logic [PM_W-1:0]       r_pm   [8];
  logic [TB_DEPTH-1:0]   r_surv [8];

  logic [PM_W-1:0]       w_c0       [8];
  logic [PM_W-1:0]       w_c1       [8];
  logic [PM_W-1:0]       w_pm_raw   [8];
  logic [PM_W-1:0]       w_pm_norm  [8];
  logic [TB_DEPTH-1:0]   w_surv_new [8];
  logic [7:0]            w_sel;
  logic [PM_W-1:0]       w_min;
  logic [2:0]            w_best;

  function automatic logic [2:0] f_pred(input logic [2:0] ns, input logic x);
    return {ns[1], ns[0], x};
  endfunction

  function automatic logic f_bit(input logic [2:0] ns, input logic x);
    return ns[2] ^ ns[0] ^ x;
  endfunction

  function automatic logic [1:0] f_exp(input logic [2:0] ns, input logic x);
    logic b;
    b = f_bit(ns, x);
    return {b ^ ns[1] ^ ns[0], b};
  endfunction

  function automatic logic [PM_W-1:0] f_cand(input logic [PM_W-1:0] pm,
                                             input logic [1:0] sym,
                                             input logic [1:0] expd);
    logic [1:0]      d;
    logic [PM_W+1:0] s;
    d = sym ^ expd;
    s = {2'b00, pm} + {{PM_W{1'b0}}, 1'b0, d[1]} + {{PM_W{1'b0}}, 1'b0, d[0]};
    return (s > {2'b00, PM_MAX}) ? PM_MAX : s[PM_W-1:0];
  endfunction

  // Add-compare-select for all eight states; ties resolve to the x=0 predecessor.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_c0[i]       = f_cand(r_pm[f_pred(3'(i), 1'b0)], d_in, f_exp(3'(i), 1'b0));
      w_c1[i]       = f_cand(r_pm[f_pred(3'(i), 1'b1)], d_in, f_exp(3'(i), 1'b1));
      w_sel[i]      = (w_c1[i] < w_c0[i]);
      w_pm_raw[i]   = w_sel[i] ? w_c1[i] : w_c0[i];
      w_surv_new[i] = {r_surv[f_pred(3'(i), w_sel[i])][TB_DEPTH-2:0], f_bit(3'(i), w_sel[i])};
    end
  end

  always_comb begin
    w_min  = w_pm_raw[0];
    w_best = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (w_pm_raw[i] < w_min) begin
        w_min  = w_pm_raw[i];
        w_best = 3'(i);
      end
    end
    for (int unsigned i = 0; i < 8; i++) begin
      w_pm_norm[i] = w_pm_raw[i] - w_min;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_dout  <= 1'b0;
      r_ready <= 1'b1;
      r_count <= '0;
      r_best  <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
        r_surv[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable_i) begin
            r_pm    <= w_pm_norm;
            r_surv  <= w_surv_new;
            r_best  <= w_best;
            r_count <= CW'(1);
            r_state <= RUN;
          end
        end
        RUN: begin
          if (enable_i) begin
            r_pm   <= w_pm_norm;
            r_surv <= w_surv_new;
            r_best <= w_best;
            // Count saturation marks the point where the survivor tail becomes final.
            if (r_count == CNT_MAX) begin
              r_valid <= 1'b1;
              r_dout  <= w_surv_new[w_best][TB_DEPTH-1];
            end else begin
              r_count <= r_count + CW'(1);
            end
          end else if (r_count == '0) begin
            r_state <= IDLE;
            for (int unsigned i = 0; i < 8; i++) begin
              r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
              r_surv[i] <= '0;
            end
          end else begin
            r_state <= FLUSH;
            r_ready <= 1'b0;
          end
        end
        FLUSH: begin
          r_valid <= 1'b1;
          r_dout  <= r_surv[r_best][r_count - CW'(1)];
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
              r_pm[i]   <= (i == 0) ? '0 : PM_MAX;
              r_surv[i] <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign d_out   = r_dout;

endmodule

// File: tb/tb_viterbi_decoder2.sv
// Scoreboard bench for viterbi_decoder2: expected bits are queued per frame and popped on valid_o.
module tb_viterbi_decoder2;

  localparam int TB   = 16;
  localparam int PMW  = 5;
  localparam int PMAX = 31;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic [1:0] d_in;
  logic       ready_o;
  logic       valid_o;
  logic       d_out;

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  logic exp_q[$];

  logic       data [64];
  logic [1:0] syms [64];
  logic       dec  [64][8];
  int         bestv[64];

  viterbi_decoder2 #(.TB_DEPTH(TB), .PM_W(PMW)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable_i(enable_i),
    .d_in    (d_in),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .d_out   (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && valid_o === 1'b1) begin
      logic e;
      n_out++;
      if (exp_q.size() == 0) begin
        check("extra_out", valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("dout", d_out, e);
      end
    end
  end

  task automatic encode(input int n);
    logic [2:0] s;
    logic       b;
    s = 3'b000;
    for (int k = 0; k < n; k++) begin
      b       = data[k];
      syms[k] = {b ^ s[2] ^ s[1], b};
      s       = {b ^ s[1] ^ s[0], s[2], s[1]};
    end
  endtask

  task automatic push_data(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(data[k]);
  endtask

  // Traceback over stored decisions from state s at step t down to step k.
  function automatic logic tb_bit(input logic [2:0] s, input int t, input int k);
    logic [2:0] st;
    st = s;
    for (int j = t; j > k; j--) st = {st[1], st[0], dec[j][st]};
    return st[2] ^ st[0] ^ dec[k][st];
  endfunction

  task automatic model(input int n);
    int pm [8];
    int npm[8];
    int mn;
    int best;
    int pend;
    for (int i = 0; i < 8; i++) pm[i] = (i == 0) ? 0 : PMAX;
    for (int t = 0; t < n; t++) begin
      for (int ns = 0; ns < 8; ns++) begin
        logic [2:0] q;
        int         c[2];
        q = 3'(ns);
        for (int x = 0; x < 2; x++) begin
          logic       b;
          logic [1:0] e;
          logic [2:0] p;
          int         bm;
          p    = {q[1], q[0], 1'(x)};
          b    = q[2] ^ q[0] ^ 1'(x);
          e    = {b ^ q[1] ^ q[0], b};
          bm   = int'(e[1] != syms[t][1]) + int'(e[0] != syms[t][0]);
          c[x] = pm[p] + bm;
          if (c[x] > PMAX) c[x] = PMAX;
        end
        dec[t][ns] = (c[1] < c[0]);
        npm[ns]    = (c[1] < c[0]) ? c[1] : c[0];
      end
      mn = npm[0]; best = 0;
      for (int i = 1; i < 8; i++) if (npm[i] < mn) begin mn = npm[i]; best = i; end
      for (int i = 0; i < 8; i++) pm[i] = npm[i] - mn;
      bestv[t] = best;
      if (t >= TB - 1) exp_q.push_back(tb_bit(3'(best), t, t - TB + 1));
    end
    pend = (n < TB - 1) ? n : TB - 1;
    for (int k = n - pend; k < n; k++) exp_q.push_back(tb_bit(3'(bestv[n-1]), n - 1, k));
  endtask

  // Drives one frame; rst_mode=1 asserts reset during the third flush cycle.
  task automatic run_frame(input int n, input int rst_mode);
    int low;
    n_out = 0;
    for (int k = 0; k < n; k++) begin
      enable_i = 1'b1;
      d_in     = syms[k];
      @(posedge clk); #1;
      check("valid_run", valid_o, (k >= TB - 1));
    end
    enable_i = 1'b0;
    d_in     = 2'b00;
    low      = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (rst_mode == 1 && c == 2) begin
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_pops", n_out, 2);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (ready_o) break;
      low++;
    end
    check("flush_ready_low", low, (n < TB - 1) ? n : TB - 1);
    repeat (3) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    check("bits_out", n_out, n);
  endtask

  task automatic rand_data(input int n);
    for (int k = 0; k < n; k++) data[k] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst      = 1'b0;
    enable_i = 1'b0;
    d_in     = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid0", valid_o, 0);
    check("rst_ready0", ready_o, 1);
    check("rst_dout0", d_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    data[0] = 1'b1; data[1] = 1'b0; data[2] = 1'b1; data[3] = 1'b1;
    encode(4); push_data(4); run_frame(4, 0);

    rand_data(40); encode(40); push_data(40); run_frame(40, 0);

    rand_data(40); encode(40); syms[20] = syms[20] ^ 2'b01;
    model(40); run_frame(40, 0);

    rand_data(20); encode(20); push_data(20); run_frame(20, 0);
    rand_data(20); encode(20); push_data(20); run_frame(20, 0);

    for (int k = 0; k < 30; k++) syms[k] = 2'b01;
    model(30); run_frame(30, 0);

    rand_data(10); encode(10); push_data(10); run_frame(10, 1);
    rand_data(5); encode(5); push_data(5); run_frame(5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
